// File: rtl/mux_int.sv
// Two-source requester mux with registered data/response/grant/conflict outputs.
// Optional build macro ARB_RR_EN selects round-robin conflict arbitration (default: source 1 wins).
module mux_int #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:DATA_W-1] in_data1,
    input  logic [0:DATA_W-1] in_data2,
    input  logic              in_sel1,
    input  logic              in_sel2,
    output logic [0:DATA_W-1] out_data,
    output logic              out_resp,
    output logic [1:0]        out_gnt,
    output logic              out_conf
);

    logic              conflict;
    logic              conf_pick2;
    logic [0:DATA_W-1] data_nxt;
    logic              resp_nxt;
    logic [1:0]        gnt_nxt;

    assign conflict = in_sel1 & in_sel2;

`ifdef ARB_RR_EN
    // state    | meaning
    // PTR_SRC1 | next conflict is granted to source 1
    // PTR_SRC2 | next conflict is granted to source 2
    typedef enum logic {PTR_SRC1 = 1'b0, PTR_SRC2 = 1'b1} ptr_t;
    ptr_t ptr, ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) ptr <= PTR_SRC1;
        else     ptr <= ptr_nxt;
    end

    // Only a conflict moves the pointer; single requests leave it alone.
    always_comb begin
        ptr_nxt = ptr;
        if (conflict) ptr_nxt = (ptr == PTR_SRC1) ? PTR_SRC2 : PTR_SRC1;
    end

    assign conf_pick2 = (ptr == PTR_SRC2);
`else
    assign conf_pick2 = 1'b0;
`endif

    always_comb begin
        data_nxt = '0;
        resp_nxt = 1'b0;
        gnt_nxt  = 2'b00;
        if (conflict) begin
            resp_nxt = 1'b1;
            if (conf_pick2) begin
                data_nxt = in_data2;
                gnt_nxt  = 2'b10;
            end else begin
                data_nxt = in_data1;
                gnt_nxt  = 2'b01;
            end
        end else if (in_sel1) begin
            data_nxt = in_data1;
            resp_nxt = 1'b1;
            gnt_nxt  = 2'b01;
        end else if (in_sel2) begin
            data_nxt = in_data2;
            resp_nxt = 1'b1;
            gnt_nxt  = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_resp <= 1'b0;
            out_gnt  <= 2'b00;
            out_conf <= 1'b0;
        end else begin
            out_data <= data_nxt;
            out_resp <= resp_nxt;
            out_gnt  <= gnt_nxt;
            out_conf <= conflict;
        end
    end

endmodule

// File: tb/tb_mux_int.sv
// Self-checking bench for mux_int: directed scenarios then random traffic
// compared against a behavioural model of the grant rules.
module tb_mux_int;

    localparam int DATA_W = 32;
`ifdef ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [0:DATA_W-1] in_data1;
    logic [0:DATA_W-1] in_data2;
    logic              in_sel1;
    logic              in_sel2;
    logic [0:DATA_W-1] out_data;
    logic              out_resp;
    logic [1:0]        out_gnt;
    logic              out_conf;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned conf_cnt = 0;

    logic [0:DATA_W-1] e_data;
    logic              e_resp;
    logic [1:0]        e_gnt;
    logic              e_conf;

    mux_int #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .in_sel1  (in_sel1),
        .in_sel2  (in_sel2),
        .out_data (out_data),
        .out_resp (out_resp),
        .out_gnt  (out_gnt),
        .out_conf (out_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, predict the registered result, check after the edge.
    task automatic step(input string tag, input logic r, input logic s1, input logic s2,
                        input logic [0:DATA_W-1] d1, input logic [0:DATA_W-1] d2);
        @(negedge clk);
        rst      = r;
        in_sel1  = s1;
        in_sel2  = s2;
        in_data1 = d1;
        in_data2 = d2;
        e_data = '0;
        e_resp = 1'b0;
        e_gnt  = 2'b00;
        e_conf = 1'b0;
        if (r) begin
            conf_cnt = 0;
        end else if (s1 && s2) begin
            e_conf = 1'b1;
            e_resp = 1'b1;
            if (RR_EN && (conf_cnt % 2) == 1) begin
                e_data = d2;
                e_gnt  = 2'b10;
            end else begin
                e_data = d1;
                e_gnt  = 2'b01;
            end
            conf_cnt++;
        end else if (s1) begin
            e_data = d1;
            e_resp = 1'b1;
            e_gnt  = 2'b01;
        end else if (s2) begin
            e_data = d2;
            e_resp = 1'b1;
            e_gnt  = 2'b10;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        assert (out_data === e_data) else begin
            n_fail++;
            $error("FAIL %s data observed=%h expected=%h", tag, out_data, e_data);
        end
        n_cmp++;
        assert (out_resp === e_resp) else begin
            n_fail++;
            $error("FAIL %s resp observed=%b expected=%b", tag, out_resp, e_resp);
        end
        n_cmp++;
        assert (out_gnt === e_gnt) else begin
            n_fail++;
            $error("FAIL %s gnt observed=%b expected=%b", tag, out_gnt, e_gnt);
        end
        n_cmp++;
        assert (out_conf === e_conf) else begin
            n_fail++;
            $error("FAIL %s conf observed=%b expected=%b", tag, out_conf, e_conf);
        end
    endtask

    initial begin
        rst = 1'b1; in_sel1 = 1'b0; in_sel2 = 1'b0; in_data1 = '0; in_data2 = '0;

        step("rst_a", 1'b1, 1'b1, 1'b1, 32'd4096, 32'd1234);
        step("rst_b", 1'b1, 1'b1, 1'b1, 32'd4096, 32'd1234);
        step("first", 1'b0, 1'b1, 1'b0, 32'd4096, 32'd1234);
        step("src1",  1'b0, 1'b1, 1'b0, 32'd4096, 32'd1234);
        step("idle",  1'b0, 1'b0, 1'b0, 32'd4096, 32'd1234);
        step("src2",  1'b0, 1'b0, 1'b1, 32'd4096, 32'd1234);
        step("conf1", 1'b0, 1'b1, 1'b1, 32'd1024, 32'd5678);
        step("conf2", 1'b0, 1'b1, 1'b1, 32'd1024, 32'd5678);
        step("conf3", 1'b0, 1'b1, 1'b1, 32'd1024, 32'd5678);
        step("trk_a", 1'b0, 1'b1, 1'b0, 32'd4096, 32'd9);
        step("trk_b", 1'b0, 1'b1, 1'b0, 32'd2048, 32'd9);
        step("trk_c", 1'b0, 1'b1, 1'b0, 32'd1024, 32'd9);
        step("ones",  1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
        step("msb",   1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        step("single_no_move", 1'b0, 1'b0, 1'b1, 32'd1, 32'd2);
        step("conf_pre", 1'b0, 1'b1, 1'b1, 32'd1024, 32'd5678);
        step("rst_conf", 1'b1, 1'b1, 1'b1, 32'd1024, 32'd5678);
        step("post_rst", 1'b0, 1'b1, 1'b1, 32'd1024, 32'd5678);
        step("post_rst2", 1'b0, 1'b1, 1'b1, 32'd1024, 32'd5678);

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
